calendar_digits: RTL and testbench

CALENDAR_DIGITS -- requirements
Module: calendar_digits

---
 rtl/calendar_digits.sv | 199 +++++++++++++++++++
 tb/tb_calendar_digits.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_digits.sv
// BCD calendar/clock: YY-MM-DD hh:mm:ss plus day-of-week, advanced by a prescaled tick strobe.
// Load has priority over tick; all digits and event pulses are registered.
module calendar_digits #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned LEAP_EN  = 1,
  parameter int unsigned DOW_EN   = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [3:0] year_h_load_i,
  input  logic [3:0] year_l_load_i,
  input  logic       month_h_load_i,
  input  logic [3:0] month_l_load_i,
  input  logic [1:0] day_h_load_i,
  input  logic [3:0] day_l_load_i,
  input  logic [1:0] hour_h_load_i,
  input  logic [3:0] hour_l_load_i,
  input  logic [2:0] minute_h_load_i,
  input  logic [3:0] minute_l_load_i,
  input  logic [2:0] second_h_load_i,
  input  logic [3:0] second_l_load_i,
  input  logic [2:0] dow_load_i,
  output logic [3:0] year_h_digit_o,
  output logic [3:0] year_l_digit_o,
  output logic       month_h_digit_o,
  output logic [3:0] month_l_digit_o,
  output logic [1:0] day_h_digit_o,
  output logic [3:0] day_l_digit_o,
  output logic [1:0] hour_h_digit_o,
  output logic [3:0] hour_l_digit_o,
  output logic [2:0] minute_h_digit_o,
  output logic [3:0] minute_l_digit_o,
  output logic [2:0] second_h_digit_o,
  output logic [3:0] second_l_digit_o,
  output logic [2:0] dow_o,
  output logic       second_o,
  output logic       minute_o,
  output logic       day_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTop = PW'(PRESCALE - 1);

  function automatic logic [7:0] bcd_val(input logic [3:0] h, input logic [3:0] l);
    return {4'd0, h} * 8'd10 + {4'd0, l};
  endfunction

  // Wrap on >= so out-of-range loaded fields recover on the next carry.
  function automatic logic at_max(input logic [3:0] h, input logic [3:0] l, input logic [7:0] maxv);
    return bcd_val(h, l) >= maxv;
  endfunction

  logic [3:0] year_h_q, year_h_d, year_l_q, year_l_d;
  logic       month_h_q, month_h_d;
  logic [3:0] month_l_q, month_l_d;
  logic [1:0] day_h_q, day_h_d, hour_h_q, hour_h_d;
  logic [3:0] day_l_q, day_l_d, hour_l_q, hour_l_d;
  logic [2:0] minute_h_q, minute_h_d, second_h_q, second_h_d;
  logic [3:0] minute_l_q, minute_l_d, second_l_q, second_l_d;
  logic [2:0] dow_q, dow_d;
  logic       sec_p_q, sec_p_d, min_p_q, min_p_d, day_p_q, day_p_d;
  logic [PW-1:0] presc_q, presc_d;

  logic       adv;
  logic       sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap, year_wrap;
  logic [7:0] mval, yval, dim;

  always_comb begin
    adv       = inc_i & ~load_i & (presc_q == PTop);
    mval      = bcd_val(4'(month_h_q), month_l_q);
    yval      = bcd_val(year_h_q, year_l_q);
    case (mval)
      8'd2:                      dim = ((LEAP_EN != 0) && (yval[1:0] == 2'b00)) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:   dim = 8'd30;
      default:                   dim = 8'd31;
    endcase
    sec_wrap  = at_max(4'(second_h_q), second_l_q, 8'd59);
    min_wrap  = at_max(4'(minute_h_q), minute_l_q, 8'd59);
    hour_wrap = at_max(4'(hour_h_q), hour_l_q, 8'd23);
    day_wrap  = at_max(4'(day_h_q), day_l_q, dim);
    mon_wrap  = at_max(4'(month_h_q), month_l_q, 8'd12);
    year_wrap = at_max(year_h_q, year_l_q, 8'd99);
  end

  always_comb begin
    presc_d = presc_q;
    if (load_i) begin
      presc_d = '0;
    end else if (inc_i) begin
      presc_d = (presc_q == PTop) ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    year_h_d   = year_h_q;   year_l_d   = year_l_q;
    month_h_d  = month_h_q;  month_l_d  = month_l_q;
    day_h_d    = day_h_q;    day_l_d    = day_l_q;
    hour_h_d   = hour_h_q;   hour_l_d   = hour_l_q;
    minute_h_d = minute_h_q; minute_l_d = minute_l_q;
    second_h_d = second_h_q; second_l_d = second_l_q;
    dow_d      = dow_q;
    sec_p_d    = 1'b0;
    min_p_d    = 1'b0;
    day_p_d    = 1'b0;
    if (load_i) begin
      year_h_d   = year_h_load_i;   year_l_d   = year_l_load_i;
      month_h_d  = month_h_load_i;  month_l_d  = month_l_load_i;
      day_h_d    = day_h_load_i;    day_l_d    = day_l_load_i;
      hour_h_d   = hour_h_load_i;   hour_l_d   = hour_l_load_i;
      minute_h_d = minute_h_load_i; minute_l_d = minute_l_load_i;
      second_h_d = second_h_load_i; second_l_d = second_l_load_i;
      dow_d      = dow_load_i;
    end else if (adv) begin
      sec_p_d = 1'b1;
      if (!sec_wrap) begin
        if (second_l_q >= 4'd9) begin second_h_d = second_h_q + 3'd1; second_l_d = '0; end
        else second_l_d = second_l_q + 4'd1;
      end else begin
        second_h_d = '0; second_l_d = '0; min_p_d = 1'b1;
        if (!min_wrap) begin
          if (minute_l_q >= 4'd9) begin minute_h_d = minute_h_q + 3'd1; minute_l_d = '0; end
          else minute_l_d = minute_l_q + 4'd1;
        end else begin
          minute_h_d = '0; minute_l_d = '0;
          if (!hour_wrap) begin
            if (hour_l_q >= 4'd9) begin hour_h_d = hour_h_q + 2'd1; hour_l_d = '0; end
            else hour_l_d = hour_l_q + 4'd1;
          end else begin
            hour_h_d = '0; hour_l_d = '0; day_p_d = 1'b1;
            dow_d = (dow_q >= 3'd6) ? 3'd0 : dow_q + 3'd1;
            if (!day_wrap) begin
              if (day_l_q >= 4'd9) begin day_h_d = day_h_q + 2'd1; day_l_d = '0; end
              else day_l_d = day_l_q + 4'd1;
            end else begin
              day_h_d = '0; day_l_d = 4'd1;
              if (!mon_wrap) begin
                if (month_l_q >= 4'd9) begin month_h_d = 1'b1; month_l_d = '0; end
                else month_l_d = month_l_q + 4'd1;
              end else begin
                month_h_d = '0; month_l_d = 4'd1;
                if (year_wrap) begin
                  year_h_d = '0; year_l_d = '0;
                end else if (year_l_q >= 4'd9) begin
                  year_h_d = year_h_q + 4'd1; year_l_d = '0;
                end else begin
                  year_l_d = year_l_q + 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      year_h_q   <= '0;   year_l_q   <= '0;
      month_h_q  <= '0;   month_l_q  <= 4'd1;
      day_h_q    <= '0;   day_l_q    <= 4'd1;
      hour_h_q   <= '0;   hour_l_q   <= '0;
      minute_h_q <= '0;   minute_l_q <= '0;
      second_h_q <= '0;   second_l_q <= '0;
      dow_q      <= 3'd6;
      sec_p_q    <= 1'b0; min_p_q    <= 1'b0; day_p_q <= 1'b0;
      presc_q    <= '0;
    end else begin
      year_h_q   <= year_h_d;   year_l_q   <= year_l_d;
      month_h_q  <= month_h_d;  month_l_q  <= month_l_d;
      day_h_q    <= day_h_d;    day_l_q    <= day_l_d;
      hour_h_q   <= hour_h_d;   hour_l_q   <= hour_l_d;
      minute_h_q <= minute_h_d; minute_l_q <= minute_l_d;
      second_h_q <= second_h_d; second_l_q <= second_l_d;
      dow_q      <= dow_d;
      sec_p_q    <= sec_p_d;    min_p_q    <= min_p_d;    day_p_q <= day_p_d;
      presc_q    <= presc_d;
    end
  end

  assign year_h_digit_o   = year_h_q;
  assign year_l_digit_o   = year_l_q;
  assign month_h_digit_o  = month_h_q;
  assign month_l_digit_o  = month_l_q;
  assign day_h_digit_o    = day_h_q;
  assign day_l_digit_o    = day_l_q;
  assign hour_h_digit_o   = hour_h_q;
  assign hour_l_digit_o   = hour_l_q;
  assign minute_h_digit_o = minute_h_q;
  assign minute_l_digit_o = minute_l_q;
  assign second_h_digit_o = second_h_q;
  assign second_l_digit_o = second_l_q;
  assign dow_o            = (DOW_EN != 0) ? dow_q : 3'd0;
  assign second_o         = sec_p_q;
  assign minute_o         = min_p_q;
  assign day_o            = day_p_q;

endmodule

// File: tb/tb_calendar_digits.sv
// Two calendar_digits instances (PRESCALE=1/leap/dow and PRESCALE=4/no-leap/no-dow) share stimulus;
// an integer-field calendar model feeds per-instance scoreboards drained by a monitor.
module tb_calendar_digits;

  typedef struct packed {
    int yr; int mo; int dy; int hr; int mi; int se; int dow;
    bit ps; bit pm; bit pd;
  } snap_t;

  typedef struct packed {
    snap_t v;
    int    cnt;
  } mst_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i, inc_i, load_i;
  logic [3:0] yh_ld, yl_ld, ml_ld, dl_ld, hl_ld, nl_ld, sl_ld;
  logic       mh_ld;
  logic [1:0] dh_ld, hh_ld;
  logic [2:0] nh_ld, sh_ld, dow_ld;

  logic [3:0] yh_o [2];
  logic [3:0] yl_o [2];
  logic       mh_o [2];
  logic [3:0] ml_o [2];
  logic [1:0] dh_o [2];
  logic [3:0] dl_o [2];
  logic [1:0] hh_o [2];
  logic [3:0] hl_o [2];
  logic [2:0] nh_o [2];
  logic [3:0] nl_o [2];
  logic [2:0] sh_o [2];
  logic [3:0] sl_o [2];
  logic [2:0] dw_o [2];
  logic       sp_o [2];
  logic       mp_o [2];
  logic       dp_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    calendar_digits #(
      .PRESCALE((g == 0) ? 1 : 4),
      .LEAP_EN ((g == 0) ? 1 : 0),
      .DOW_EN  ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .inc_i           (inc_i),
      .load_i          (load_i),
      .year_h_load_i   (yh_ld),
      .year_l_load_i   (yl_ld),
      .month_h_load_i  (mh_ld),
      .month_l_load_i  (ml_ld),
      .day_h_load_i    (dh_ld),
      .day_l_load_i    (dl_ld),
      .hour_h_load_i   (hh_ld),
      .hour_l_load_i   (hl_ld),
      .minute_h_load_i (nh_ld),
      .minute_l_load_i (nl_ld),
      .second_h_load_i (sh_ld),
      .second_l_load_i (sl_ld),
      .dow_load_i      (dow_ld),
      .year_h_digit_o  (yh_o[g]),
      .year_l_digit_o  (yl_o[g]),
      .month_h_digit_o (mh_o[g]),
      .month_l_digit_o (ml_o[g]),
      .day_h_digit_o   (dh_o[g]),
      .day_l_digit_o   (dl_o[g]),
      .hour_h_digit_o  (hh_o[g]),
      .hour_l_digit_o  (hl_o[g]),
      .minute_h_digit_o(nh_o[g]),
      .minute_l_digit_o(nl_o[g]),
      .second_h_digit_o(sh_o[g]),
      .second_l_digit_o(sl_o[g]),
      .dow_o           (dw_o[g]),
      .second_o        (sp_o[g]),
      .minute_o        (mp_o[g]),
      .day_o           (dp_o[g])
    );
  end

  int    checks = 0;
  int    passes = 0;
  mst_t  m [2];
  snap_t q0[$];
  snap_t q1[$];
  snap_t nolv = '0;

  function automatic int kp(int k); return (k == 0) ? 1 : 4; endfunction
  function automatic bit kleap(int k); return k == 0; endfunction
  function automatic bit kdow(int k); return k == 0; endfunction

  function automatic snap_t mk(int yr, int mo, int dy, int hr, int mi, int se, int dow,
                               bit ps = 0, bit pm = 0, bit pd = 0);
    snap_t s;
    s.yr = yr; s.mo = mo; s.dy = dy; s.hr = hr; s.mi = mi; s.se = se; s.dow = dow;
    s.ps = ps; s.pm = pm; s.pd = pd;
    return s;
  endfunction

  function automatic snap_t rst_snap(bit dowen);
    return mk(0, 1, 1, 0, 0, 0, dowen ? 6 : 0);
  endfunction

  function automatic int days_in(int mo, int yr, bit leap);
    case (mo)
      2:             return (leap && (yr % 4 == 0)) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  // Calendar reference: fields held as plain integers, each wraps once it reaches its maximum.
  function automatic mst_t mstep(mst_t s, bit inc, bit ld, snap_t lv, int p, bit leap, bit dowen);
    mst_t n = s;
    n.v.ps = 0; n.v.pm = 0; n.v.pd = 0;
    if (ld) begin
      n.v = lv;
      n.v.ps = 0; n.v.pm = 0; n.v.pd = 0;
      n.v.dow = dowen ? lv.dow : 0;
      n.cnt = 0;
    end else if (inc) begin
      if (s.cnt < p - 1) begin
        n.cnt = s.cnt + 1;
      end else begin
        n.cnt = 0;
        n.v.ps = 1;
        if (n.v.se < 59) n.v.se = n.v.se + 1;
        else begin
          n.v.se = 0; n.v.pm = 1;
          if (n.v.mi < 59) n.v.mi = n.v.mi + 1;
          else begin
            n.v.mi = 0;
            if (n.v.hr < 23) n.v.hr = n.v.hr + 1;
            else begin
              n.v.hr = 0; n.v.pd = 1;
              if (dowen) n.v.dow = (n.v.dow + 1) % 7;
              if (n.v.dy < days_in(n.v.mo, n.v.yr, leap)) n.v.dy = n.v.dy + 1;
              else begin
                n.v.dy = 1;
                if (n.v.mo < 12) n.v.mo = n.v.mo + 1;
                else begin
                  n.v.mo = 1;
                  n.v.yr = (n.v.yr + 1) % 100;
                end
              end
            end
          end
        end
      end
    end
    return n;
  endfunction

  function automatic snap_t dut_snap(int k);
    snap_t s;
    s.yr  = int'(yh_o[k]) * 10 + int'(yl_o[k]);
    s.mo  = int'(mh_o[k]) * 10 + int'(ml_o[k]);
    s.dy  = int'(dh_o[k]) * 10 + int'(dl_o[k]);
    s.hr  = int'(hh_o[k]) * 10 + int'(hl_o[k]);
    s.mi  = int'(nh_o[k]) * 10 + int'(nl_o[k]);
    s.se  = int'(sh_o[k]) * 10 + int'(sl_o[k]);
    s.dow = int'(dw_o[k]);
    s.ps  = sp_o[k]; s.pm = mp_o[k]; s.pd = dp_o[k];
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("%0d-%0d-%0d %0d:%0d:%0d dow=%0d pulses(s,m,d)=%0d%0d%0d",
                     s.yr, s.mo, s.dy, s.hr, s.mi, s.se, s.dow, s.ps, s.pm, s.pd);
  endfunction

  task automatic cmp(string nm, int k, snap_t got, snap_t exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s dut%0d @%0t: got %s, required %s", nm, k, $time, fmt(got), fmt(exp));
  endtask

  function automatic snap_t rand_lv();
    return mk($urandom % 100, 1 + $urandom % 12, $urandom % 40, $urandom % 40,
              $urandom % 80, $urandom % 80, $urandom % 7);
  endfunction

  task automatic step(bit inc, bit ld, snap_t lv);
    @(negedge clk_i);
    inc_i  = inc;
    load_i = ld;
    yh_ld  = 4'(lv.yr / 10); yl_ld = 4'(lv.yr % 10);
    mh_ld  = 1'(lv.mo / 10); ml_ld = 4'(lv.mo % 10);
    dh_ld  = 2'(lv.dy / 10); dl_ld = 4'(lv.dy % 10);
    hh_ld  = 2'(lv.hr / 10); hl_ld = 4'(lv.hr % 10);
    nh_ld  = 3'(lv.mi / 10); nl_ld = 4'(lv.mi % 10);
    sh_ld  = 3'(lv.se / 10); sl_ld = 4'(lv.se % 10);
    dow_ld = 3'(lv.dow);
    for (int k = 0; k < 2; k++) m[k] = mstep(m[k], inc, ld, lv, kp(k), kleap(k), kdow(k));
    q0.push_back(m[0].v);
    q1.push_back(m[1].v);
  endtask

  task automatic check_now(string nm, int k, snap_t exp);
    @(posedge clk_i);
    #2;
    cmp(nm, k, dut_snap(k), exp);
  endtask

  // Reset pulse wholly between two clock edges; outputs must clear without a clock.
  task automatic areset();
    @(negedge clk_i);
    inc_i = 1'b0; load_i = 1'b0;
    #1 rst_i = 1'b0;
    #1 for (int k = 0; k < 2; k++) cmp("async_reset", k, dut_snap(k), rst_snap(kdow(k)));
    #1 rst_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m[k].v   = rst_snap(kdow(k));
      m[k].cnt = 0;
    end
    q0.push_back(m[0].v);
    q1.push_back(m[1].v);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk_i);
      #1;
      if (q0.size() > 0) cmp("scoreboard", 0, dut_snap(0), q0.pop_front());
      if (q1.size() > 0) cmp("scoreboard", 1, dut_snap(1), q1.pop_front());
    end
  end

  initial begin : driver
    rst_i = 1'b1; inc_i = 1'b0; load_i = 1'b0;
    yh_ld = '0; yl_ld = '0; mh_ld = '0; ml_ld = '0; dh_ld = '0; dl_ld = '0;
    hh_ld = '0; hl_ld = '0; nh_ld = '0; nl_ld = '0; sh_ld = '0; sl_ld = '0; dow_ld = '0;
    for (int k = 0; k < 2; k++) begin
      m[k].v   = rst_snap(kdow(k));
      m[k].cnt = 0;
    end
    #1 rst_i = 1'b0;
    #11;
    for (int k = 0; k < 2; k++) cmp("reset_state", k, dut_snap(k), rst_snap(kdow(k)));
    rst_i = 1'b1;

    // Prescale of 4 on dut1: 7 pulses give one advance, the 8th a second one.
    repeat (6) begin step(1, 0, nolv); step(0, 0, nolv); end
    step(1, 0, nolv);
    check_now("presc_7th", 1, mk(0, 1, 1, 0, 0, 1, 0));
    step(0, 0, nolv);
    step(1, 0, nolv);
    check_now("presc_8th", 1, mk(0, 1, 1, 0, 0, 2, 0, 1));
    repeat (3) begin step(1, 0, nolv); step(0, 0, nolv); end
    step(0, 1, mk(0, 1, 1, 0, 0, 0, 3));
    repeat (2) begin step(1, 0, nolv); step(0, 0, nolv); end
    step(1, 0, nolv);
    check_now("presc_cleared_by_load", 1, mk(0, 1, 1, 0, 0, 0, 0));

    step(0, 1, mk(99, 12, 31, 23, 59, 59, 5));
    step(1, 0, nolv);
    check_now("century_rollover", 0, mk(0, 1, 1, 0, 0, 0, 6, 1, 1, 1));

    step(0, 1, mk(24, 2, 28, 23, 59, 59, 0));
    step(1, 0, nolv);
    check_now("leap_feb29", 0, mk(24, 2, 29, 0, 0, 0, 1, 1, 1, 1));
    step(1, 0, nolv);
    step(1, 0, nolv);
    step(1, 0, nolv);
    check_now("noleap_en_mar1", 1, mk(24, 3, 1, 0, 0, 0, 0, 1, 1, 1));
    step(0, 1, mk(23, 2, 28, 23, 59, 59, 0));
    step(1, 0, nolv);
    check_now("nonleap_year_mar1", 0, mk(23, 3, 1, 0, 0, 0, 1, 1, 1, 1));

    step(1, 1, mk(7, 6, 15, 12, 34, 56, 4));
    check_now("load_beats_inc", 0, mk(7, 6, 15, 12, 34, 56, 4));

    step(0, 1, mk(10, 4, 31, 23, 59, 59, 2));
    step(1, 0, nolv);
    check_now("april31_wrap", 0, mk(10, 5, 1, 0, 0, 0, 3, 1, 1, 1));

    repeat (5) step(1, 0, nolv);
    areset();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 400 == 0) areset();
      else step(($urandom % 3) != 0, ($urandom % 40) == 0, rand_lv());
    end

    step(0, 0, nolv);
    @(posedge clk_i);
    #2;
    checks++;
    if (q0.size() + q1.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d entries left, required 0", q0.size() + q1.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
